// File: rtl/mem_port_arb.sv
// mem_port_arb: buffers IF and MEM-stage request pulses in one-entry slots and serialises them onto one memory port.
// Optional macro MEM_ARB_RR_EN: round-robin between the two slots when both are full (default: data beats instruction).
module mem_port_arb #(
    parameter int          TIMEOUT_W = 4,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_ren,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic [3:0]  da_ren,
    input  logic [3:0]  da_wen,
    input  logic [31:0] da_addr,
    input  logic [31:0] da_wdata,
    output logic        da_valid,
    output logic [31:0] da_rdata,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_ovf,
    output logic        err_tmo
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_d;
    logic                 if_full_q;
    logic [31:0]          if_addr_q;
    logic                 da_full_q;
    logic [3:0]           da_we_q;
    logic [31:0]          da_addr_q;
    logic [31:0]          da_wdata_q;
    logic                 owner_da_q;
    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic [TIMEOUT_W-1:0] tmo_inc;

    logic        da_pulse;
    logic        da_wins;
    logic        grant_if, grant_da;
    logic        rd_done, rd_tmo;
    logic [31:0] rsp_data;

    assign da_pulse = (|da_ren) | (|da_wen);
    assign tmo_inc  = tmo_cnt_q + TIMEOUT_W'(1);
    assign rsp_data = rd_tmo ? ERR_DATA : mem_rdata;

`ifdef MEM_ARB_RR_EN
    logic last_da_q;  // 1 when the most recent grant went to the data port

    assign da_wins = !(if_full_q && last_da_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        last_da_q <= 1'b0;
        else if (mem_req) last_da_q <= grant_da;
    end
`else
    assign da_wins = 1'b1;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_da = 1'b0;
        rd_done  = 1'b0;
        rd_tmo   = 1'b0;
        case (state_q)
            IDLE: begin
                grant_da = da_full_q && da_wins;
                grant_if = if_full_q && !grant_da;
                if (grant_if || (grant_da && da_we_q == 4'd0)) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end else if (&tmo_inc) begin
                    rd_tmo  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = grant_if | grant_da;
    assign mem_we    = grant_da ? da_we_q : 4'd0;
    assign mem_addr  = grant_da ? da_addr_q : (grant_if ? if_addr_q : 32'd0);
    assign mem_wdata = grant_da ? da_wdata_q : 32'd0;

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= '0;
            owner_da_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mem_req) begin
                tmo_cnt_q  <= '0;
                owner_da_q <= grant_da;
            end else if (state_q == WAIT) begin
                tmo_cnt_q <= tmo_inc;
            end
        end
    end

    // NOTE: slot payloads are reset along with the full flags so the whole slot is empty after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_full_q  <= 1'b0;
            if_addr_q  <= '0;
            da_full_q  <= 1'b0;
            da_we_q    <= '0;
            da_addr_q  <= '0;
            da_wdata_q <= '0;
        end else begin
            // A pulse landing on the grant cycle reloads the slot instead of being dropped.
            if (if_ren && (!if_full_q || grant_if)) begin
                if_full_q <= 1'b1;
                if_addr_q <= if_addr;
            end else if (grant_if) begin
                if_full_q <= 1'b0;
            end
            if (da_pulse && (!da_full_q || grant_da)) begin
                da_full_q  <= 1'b1;
                da_we_q    <= da_wen;
                da_addr_q  <= da_addr;
                da_wdata_q <= da_wdata;
            end else if (grant_da) begin
                da_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_valid <= 1'b0;
            if_rdata <= '0;
            da_valid <= 1'b0;
            da_rdata <= '0;
            err_ovf  <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            da_valid <= 1'b0;
            if (grant_da && da_we_q != 4'd0) begin
                da_valid <= 1'b1;
                da_rdata <= '0;
            end
            if (rd_done || rd_tmo) begin
                if (owner_da_q) begin
                    da_valid <= 1'b1;
                    da_rdata <= rsp_data;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= rsp_data;
                end
            end
            err_ovf <= err_ovf | (if_ren && if_full_q && !grant_if)
                               | (da_pulse && da_full_q && !grant_da);
            err_tmo <= err_tmo | rd_tmo;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed scenarios plus a randomized phase checked against a transaction-level model of the arbiter.
module tb_mem_port_arb;

    localparam logic [31:0] RD_KEY = 32'h1E80_0000;  // memory returns addr ^ RD_KEY

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_ren;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic [3:0]  da_ren;
    logic [3:0]  da_wen;
    logic [31:0] da_addr;
    logic [31:0] da_wdata;
    logic        da_valid;
    logic [31:0] da_rdata;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'h0;
    logic        err_ovf;
    logic        err_tmo;

    always #5 clk = ~clk;

    mem_port_arb dut (
        .clk(clk), .rstn(rstn),
        .if_ren(if_ren), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .da_ren(da_ren), .da_wen(da_wen), .da_addr(da_addr), .da_wdata(da_wdata),
        .da_valid(da_valid), .da_rdata(da_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .err_ovf(err_ovf), .err_tmo(err_tmo)
    );

    typedef struct { int cyc; logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int cyc; logic [31:0] data; } rsp_t;
    typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { int due; logic [31:0] data; bit is_rd; } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mem_lat = 1;  // 0: memory never answers
    int   pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int   idle_bad = 0;
    req_t req_log[$];
    rsp_t if_log[$];
    rsp_t da_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers a read mem_lat cycles after its request, whatever the arbiter state.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_addr ^ RD_KEY;
            end
        end
        if (mem_req && mem_we == 4'h0 && mem_lat > 0) begin
            pend_cnt  = mem_lat;
            pend_addr = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (mem_req) req_log.push_back(req_t'{cyc, mem_we, mem_addr, mem_wdata});
        else if (mem_we != 4'h0 || mem_addr != 32'h0 || mem_wdata != 32'h0) idle_bad++;
        if (if_valid) if_log.push_back(rsp_t'{cyc, if_rdata});
        if (da_valid) da_log.push_back(rsp_t'{cyc, da_rdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctl"}, {27'h0, mem_req, if_valid, da_valid, err_ovf, err_tmo}, 32'h0);
        check({tag, ".mem"}, {28'h0, mem_we} | mem_addr | mem_wdata, 32'h0);
        check({tag, ".if_rdata"}, if_rdata, 32'h0);
        check({tag, ".da_rdata"}, da_rdata, 32'h0);
    endtask

    function automatic req_t req_at(int i);
        req_t r = '{-1, 4'h0, 32'h0, 32'h0};
        if (i < req_log.size()) r = req_log[i];
        return r;
    endfunction

    function automatic rsp_t if_at(int i);
        rsp_t r = '{-1, 32'h0};
        if (i < if_log.size()) r = if_log[i];
        return r;
    endfunction

    function automatic rsp_t da_at(int i);
        rsp_t r = '{-1, 32'h0};
        if (i < da_log.size()) r = da_log[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if_ren = 1'b0;
        da_ren = 4'h0;
        da_wen = 4'h0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        if_log.delete();
        da_log.delete();
    endtask

    initial begin
        int   t;
        bit   has_if, has_da, from_da, rd_busy, exp_req;
        txn_t nt_if, nt_da, g;
        exp_t e;
        txn_t pend_if[$];
        txn_t pend_da[$];
        exp_t exp_if[$];
        exp_t exp_da[$];

        rstn = 1'b0; if_ren = 1'b0; if_addr = 32'h0;
        da_ren = 4'h0; da_wen = 4'h0; da_addr = 32'h0; da_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        // Instruction read, L=1: request at T+1, valid at T+3.
        clear_logs();
        t = cyc; if_ren = 1'b1; if_addr = 32'h1C00_0000;
        tick(); repeat (6) tick();
        check("t1.nreq", req_log.size(), 1);
        check("t1.req_cyc", req_at(0).cyc, t + 1);
        check("t1.req_addr", req_at(0).addr, 32'h1C00_0000);
        check("t1.req_we_wdata", {28'h0, req_at(0).we} | req_at(0).wdata, 32'h0);
        check("t1.nif", if_log.size(), 1);
        check("t1.if_cyc", if_at(0).cyc, t + 3);
        check("t1.if_data", if_at(0).data, 32'h0280_0000);
        check("t1.nda", da_log.size(), 0);
        check("t1.if_hold", if_rdata, 32'h0280_0000);

        // Simultaneous pulses: data first, instruction issued as da_valid rises.
        clear_logs();
        t = cyc; if_ren = 1'b1; if_addr = 32'h1C00_0004;
        da_ren = 4'hF; da_addr = 32'h0000_0100; da_wdata = 32'h0;
        tick(); repeat (8) tick();
        check("t2.nreq", req_log.size(), 2);
        check("t2.req0_addr", req_at(0).addr, 32'h0000_0100);
        check("t2.req0_cyc", req_at(0).cyc, t + 1);
        check("t2.req1_addr", req_at(1).addr, 32'h1C00_0004);
        check("t2.req1_cyc", req_at(1).cyc, t + 3);
        check("t2.da_cyc", da_at(0).cyc, t + 3);
        check("t2.da_data", da_at(0).data, 32'h0000_0100 ^ RD_KEY);
        check("t2.if_cyc", if_at(0).cyc, t + 5);
        check("t2.if_data", if_at(0).data, 32'h1C00_0004 ^ RD_KEY);

        // Byte write, then a read pulse on the write's grant cycle (reload, back-to-back issue).
        clear_logs();
        t = cyc; da_wen = 4'b0100; da_addr = 32'h0000_0200; da_wdata = 32'h00AB_0000;
        tick();
        da_ren = 4'h3; da_addr = 32'h0000_0204; da_wdata = 32'h0;
        tick(); repeat (6) tick();
        check("t3.nreq", req_log.size(), 2);
        check("t3.req0_cyc", req_at(0).cyc, t + 1);
        check("t3.req0_we", req_at(0).we, 4'b0100);
        check("t3.req0_wdata", req_at(0).wdata, 32'h00AB_0000);
        check("t3.req0_addr", req_at(0).addr, 32'h0000_0200);
        check("t3.req1_cyc", req_at(1).cyc, t + 2);
        check("t3.req1_we", req_at(1).we, 4'h0);
        check("t3.nda", da_log.size(), 2);
        check("t3.wr_done_cyc", da_at(0).cyc, t + 2);
        check("t3.wr_done_data", da_at(0).data, 32'h0);
        check("t3.rd_cyc", da_at(1).cyc, t + 4);
        check("t3.rd_data", da_at(1).data, 32'h0000_0204 ^ RD_KEY);
        check("t3.no_ovf", err_ovf, 1'b0);

        // Overflow: second data pulse while the slot waits behind an instruction read.
        clear_logs();
        mem_lat = 3;
        t = cyc; if_ren = 1'b1; if_addr = 32'h1C00_0010;
        tick();
        da_ren = 4'hF; da_addr = 32'h0000_0300;
        tick();
        check("t4.ovf_before", err_ovf, 1'b0);
        da_ren = 4'hF; da_addr = 32'h0000_0304;
        tick();
        check("t4.ovf_set", err_ovf, 1'b1);
        repeat (12) tick();
        check("t4.if_cyc", if_at(0).cyc, t + 5);
        check("t4.nreq", req_log.size(), 2);
        check("t4.req1_addr", req_at(1).addr, 32'h0000_0300);
        check("t4.req1_cyc", req_at(1).cyc, t + 5);
        check("t4.nda", da_log.size(), 1);
        check("t4.da_cyc", da_at(0).cyc, t + 9);
        check("t4.da_data", da_at(0).data, 32'h0000_0300 ^ RD_KEY);
        check("t4.ovf_sticky", err_ovf, 1'b1);

        // Timeout: memory silent, response 15 WAIT cycles after the grant.
        clear_logs();
        mem_lat = 0;
        t = cyc; da_ren = 4'h1; da_addr = 32'h0000_0400;
        tick();
        check("t5.tmo_before", err_tmo, 1'b0);
        repeat (20) tick();
        check("t5.nda", da_log.size(), 1);
        check("t5.da_cyc", da_at(0).cyc, t + 17);
        check("t5.da_data", da_at(0).data, 32'hDEAD_BEEF);
        check("t5.tmo_set", err_tmo, 1'b1);
        clear_logs();
        mem_lat = 1;
        t = cyc; if_ren = 1'b1; if_addr = 32'h1C00_0020;
        tick(); repeat (4) tick();
        check("t5.idle_req_cyc", req_at(0).cyc, t + 1);
        check("t5.idle_if_cyc", if_at(0).cyc, t + 3);

        // Reset during WAIT; the late memory response must be ignored.
        mem_lat = 5;
        t = cyc; if_ren = 1'b1; if_addr = 32'h1C00_0030;
        tick(); tick(); tick();
        clear_logs();
        rstn = 1'b0;
        #1;
        check_all_zero("t6.in_reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (8) tick();
        check("t6.nreq", req_log.size(), 0);
        check("t6.nif", if_log.size(), 0);
        check("t6.nda", da_log.size(), 0);
        check_all_zero("t6.after");

        // Randomized traffic against a transaction-level model.
        rd_busy = 1'b0;
        for (int i = 0; i < 400; i++) begin
            has_if = (i < 370) && (pend_if.size() == 0) && ($urandom_range(0, 2) == 0);
            has_da = (i < 370) && (pend_da.size() == 0) && ($urandom_range(0, 2) == 0);
            mem_lat = int'($urandom_range(1, 4));
            if (has_if) begin
                if_ren  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
                nt_if   = '{4'h0, if_addr, 32'h0};
            end
            if (has_da) begin
                da_addr  = $urandom & 32'hFFFF_FFFC;
                da_wdata = $urandom;
                if ($urandom_range(0, 1) == 1) begin
                    da_wen = 4'($urandom_range(1, 15));
                    da_ren = 4'($urandom_range(0, 15));
                end else begin
                    da_ren = 4'($urandom_range(1, 15));
                    da_wen = 4'h0;
                end
                nt_da = '{da_wen, da_addr, da_wdata};
            end
            @(negedge clk);
            if (if_valid) begin
                check("rnd.if_expected", exp_if.size() > 0, 1'b1);
                if (exp_if.size() > 0) begin
                    e = exp_if.pop_front();
                    check("rnd.if_cyc", cyc, e.due);
                    check("rnd.if_data", if_rdata, e.data);
                    if (e.is_rd) rd_busy = 1'b0;
                end
            end
            if (da_valid) begin
                check("rnd.da_expected", exp_da.size() > 0, 1'b1);
                if (exp_da.size() > 0) begin
                    e = exp_da.pop_front();
                    check("rnd.da_cyc", cyc, e.due);
                    check("rnd.da_data", da_rdata, e.data);
                    if (e.is_rd) rd_busy = 1'b0;
                end
            end
            exp_req = !rd_busy && (pend_if.size() + pend_da.size() > 0);
            check("rnd.mem_req", mem_req, exp_req);
            if (mem_req && exp_req) begin
                from_da = (pend_da.size() != 0);
                if (from_da) g = pend_da.pop_front();
                else         g = pend_if.pop_front();
                check("rnd.mem_addr", mem_addr, g.addr);
                check("rnd.mem_we", mem_we, g.we);
                check("rnd.mem_wdata", mem_wdata, g.wdata);
                if (g.we == 4'h0) begin
                    rd_busy = 1'b1;
                    e = exp_t'{cyc + mem_lat + 1, g.addr ^ RD_KEY, 1'b1};
                    if (from_da) exp_da.push_back(e);
                    else         exp_if.push_back(e);
                end else begin
                    exp_da.push_back(exp_t'{cyc + 1, 32'h0, 1'b0});
                end
            end
            if (has_if) pend_if.push_back(nt_if);
            if (has_da) pend_da.push_back(nt_da);
            tick();
        end
        check("rnd.pend_empty", pend_if.size() + pend_da.size(), 0);
        check("rnd.exp_empty", exp_if.size() + exp_da.size(), 0);
        check("rnd.no_ovf", err_ovf, 1'b0);
        check("rnd.no_tmo", err_tmo, 1'b0);
        check("idle_fields_zero", idle_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Arbitrates the single unified memory port between two requesters: the instruction-fetch request port (if_*) and the MEM-stage data request port (da_*).
- Both requesters issue one-cycle request pulses.
- The block buffers each pulse in a one-entry slot, serialises the slots onto the memory port, and returns read data or write completion to the owning requester.
- It sits between the core's IF/MEM request logic and the external SRAM-like memory interface.

Parameters:
- TIMEOUT_W, 4, width of the response-timeout counter; the timeout fires after 2^TIMEOUT_W-1 WAIT cycles.
- ERR_DATA, 32'hDEAD_BEEF, read data returned to the requester on timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- if_ren  in  1  instruction read pulse, one cycle
- if_addr  in  32  instruction address, word aligned
- if_valid  out  1  instruction read data valid, one-cycle pulse
- if_rdata  out  32  instruction read data
- da_ren  in  4  data read enable, nonzero = read pulse
- da_wen  in  4  data byte write enables, nonzero = write pulse
- da_addr  in  32  data address, word aligned
- da_wdata  in  32  data write data, lane-aligned
- da_valid  out  1  data read data valid, or write done; one-cycle pulse
- da_rdata  out  32  data read data; 0 for writes
- mem_req  out  1  memory request strobe, one cycle
- mem_we  out  4  byte write enables, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rvalid  in  1  memory read response valid
- mem_rdata  in  32  memory read response data
- err_ovf  out  1  sticky: a pulse arrived while its slot was occupied
- err_tmo  out  1  sticky: a read response timed out

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs, both slots, the FSM state, the timeout counter, the sticky error flags and the last-grant flag clear to 0. The FSM enters IDLE.
- Reset mid-transaction aborts the transaction. No response pulse is produced, and a late mem_rvalid after reset is ignored in IDLE.
- Capture:
  - A pulse (if_ren=1, or da_ren!=0, or da_wen!=0) at cycle T sets the requester's slot at T+1.
  - The data slot stores addr, wdata and we=da_wen. we=0 marks a read.
  - If da_ren and da_wen are both nonzero, the write wins.
- Slot clear: a slot clears on the cycle it is granted.
  - A new pulse on the grant cycle is accepted and reloads the slot; set wins over clear.
  - A pulse while the slot is full and not being granted is dropped and sets err_ovf.
- FSM states: IDLE, WAIT.
- IDLE, no slot full: remain in IDLE; mem_req=0.
- IDLE, one or both slots full:
  - Grant one slot. The default priority is fixed: data beats instruction.
  - Drive mem_req=1 with the slot's we/addr/wdata for exactly that cycle. Instruction grants use we=0 and wdata=0.
  - Record the owner and the last-grant flag.
- Write grant: stay in IDLE. da_valid=1 and da_rdata=0 on the next cycle. Back-to-back issue is allowed.
- Read grant: go to WAIT and clear the timeout counter.
- WAIT, mem_rvalid=1:
  - Register mem_rdata to the owner's rdata and pulse the owner's valid on the next cycle.
  - Return to IDLE. A new grant may issue in the same cycle that the valid pulse appears.
- WAIT, mem_rvalid=0: increment the counter. At all-ones, return ERR_DATA to the owner, set err_tmo and go to IDLE.
- mem_rvalid in IDLE is ignored.
- Outside the above pulse cycles, mem_req, if_valid and da_valid are 0.
- mem_* fields are 0 when mem_req=0.
- rdata outputs hold their last value.
- Minimum read latency: pulse at T, mem_req at T+1, memory latency L, valid at T+2+L.
- Minimum write latency: pulse at T, mem_req at T+1, da_valid at T+2.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both slots are full in IDLE, grant the requester that was not granted last (round-robin on ties). A single full slot is always granted.
- Undefined: fixed data-over-instruction priority. The last-grant flag is not implemented.

Test Plan:
- if_ren pulse at T with addr 0x1C000000, memory returns 0x02800000 after L=1 -> mem_req/mem_addr at T+1; if_valid=1 with if_rdata=0x02800000 at T+3.
- Simultaneous if_ren (0x1C000004) and da_ren=4'hF (0x00000100) at T -> data granted first at T+1; instruction mem_req on the cycle da_valid rises. With MEM_ARB_RR_EN and last grant=data -> instruction granted first.
- da_wen=4'b0100, da_wdata=0x00AB0000, addr 0x00000200 -> mem_we=4'b0100, mem_wdata=0x00AB0000 at T+1; da_valid=1 with da_rdata=0 at T+2; no WAIT.
- Second da_ren pulse while the data slot is full and the FSM is in WAIT on an instruction read -> pulse dropped, err_ovf=1 and sticky; the first data read still completes.
- Read with mem_rvalid never asserted, TIMEOUT_W=4 -> response 15 WAIT cycles after grant with rdata=0xDEADBEEF and err_tmo=1; FSM back in IDLE.
- rstn low during WAIT, then mem_rvalid after release -> no if_valid/da_valid pulse; all outputs 0; slots empty.
